parity_frame_rx: RTL and testbench

- Receive-side counterpart of the team's combinational parity generator.
- Deserialises a bit-serial frame: start bit, DATA_W data bits LSB first, one parity bit, one stop bit.
- Checks even or odd parity and stop-bit framing, then presents the recovered word with a one-cycle valid strobe and error flags.
- Sits between a bit-level line interface (one bit per ser_valid strobe) and byte-level consumers.

---
 rtl/parity_frame_rx_if.sv | 51 +++++
 rtl/parity_frame_rx.sv | 144 ++++++++++++++
 tb/tb_parity_frame_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/parity_frame_rx_if.sv
// parity_frame_rx_if
//   Bundles the bit-serial line side and the word-level result side of
//   parity_frame_rx.
//   Line side   : ser_in, ser_valid, par_mode (driven by the line master)
//   Result side : data_out[DATA_W-1:0], data_valid, parity_err, frame_err,
//                 busy, and err_cnt[7:0] when PARITY_FRAME_RX_ERRCNT_EN is
//                 defined
//   Modports    : master (line driver / result consumer), slave (receiver)
interface parity_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              ser_in;
  logic              ser_valid;
  logic              par_mode;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0]        err_cnt;
`endif

  modport master (
    output ser_in,
    output ser_valid,
    output par_mode,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    input  err_cnt,
`endif
    input  busy
  );

  modport slave (
    input  ser_in,
    input  ser_valid,
    input  par_mode,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    output err_cnt,
`endif
    output busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//   Bit-serial frame receiver: start bit (0), DATA_W data bits LSB first,
//   one parity bit, one stop bit (1). One line bit is consumed per cycle
//   with ser_valid=1; idle gaps between strobes are allowed anywhere.
//   par_mode (0 = even, 1 = odd) is latched on the start-bit strobe.
//   Results are registered on the stop-bit strobe and appear the next
//   cycle with a one-cycle data_valid pulse.
// Ports
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : parity_frame_rx_if.slave (see interface for signal list)
// Optional feature
//   PARITY_FRAME_RX_ERRCNT_EN : adds saturating 8-bit err_cnt counting
//   frames delivered with parity_err or frame_err set.
module parity_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  parity_frame_rx_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               mode_q, mode_d;
  logic               par_bit_q, par_bit_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0]         err_cnt_q, err_cnt_d;
`endif

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    mode_d       = mode_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    if (bus.ser_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.ser_in) begin
            mode_d  = bus.par_mode;
            shift_d = '0;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bus.ser_in;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_bit_d = bus.ser_in;
          state_d   = STOP;
        end
        STOP: begin
          // A bad stop bit still delivers the word as received.
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = ((^shift_q) ^ par_bit_q) != mode_q;
          frame_err_d  = ~bus.ser_in;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
          if ((parity_err_d || frame_err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
`endif
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      mode_q       <= 1'b0;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      mode_q       <= mode_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  assign bus.err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx
//   Directed bench for parity_frame_rx. Expected words are queued when a
//   frame is driven and compared when data_valid pulses.
module tb_parity_frame_rx;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t exp_q[$];

  parity_frame_rx_if #(.DATA_W(DW)) bus ();

  parity_frame_rx #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: compare every delivered word, and check pulse width.
  logic dv_prev;
  initial dv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (dv_prev) chk("dv_one_cycle", {31'd0, bus.data_valid}, 32'd0);
      if (bus.data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_out",   {24'd0, bus.data_out},   {24'd0, e.d});
          chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
          chk("frame_err",  {31'd0, bus.frame_err},  {31'd0, e.fe});
        end
      end
    end
    dv_prev = bus.data_valid;
  end

  // One strobe, then 'gap' idle cycles (optionally checking busy stays high).
  task automatic send_bit(input logic b, input int gap, input bit chk_busy);
    bus.ser_valid = 1'b1;
    bus.ser_in    = b;
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b1;
    for (int g = 0; g < gap; g++) begin
      if (chk_busy) chk("busy_gap", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                            input logic mode, input int gap, input bit toggle);
    exp_t e;
    logic ones;
    ones = ^d;
    e.d  = d;
    e.pe = (ones ^ p) != mode;
    e.fe = ~s;
    exp_q.push_back(e);
    bus.par_mode = mode;
    send_bit(1'b0, gap, gap > 0);
    if (toggle) bus.par_mode = ~mode;
    for (int i = 0; i < DW; i++) send_bit(d[i], gap, gap > 0);
    send_bit(p, gap, gap > 0);
    send_bit(s, 0, 1'b0);
    chk("latency1", {31'd0, bus.data_valid}, 32'd1);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.ser_in   = 1'b1;
    bus.ser_valid = 1'b0;
    bus.par_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_data_out",   {24'd0, bus.data_out},   32'd0);
    chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    chk("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
    chk("rst_busy",       {31'd0, bus.busy},       32'd0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("rst_err_cnt",    {24'd0, bus.err_cnt},    32'd0);
`endif

    // Idle-line ones do not start a frame.
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    chk("idle_ones_busy", {31'd0, bus.busy}, 32'd0);

    // Even mode, clean frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    chk("hold_data_out", {24'd0, bus.data_out}, 32'h0000_00A5);

    // Odd mode, wrong then right parity, back-to-back (no idle cycle).
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Framing error, then a clean frame clears it.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);

    // Gapped frame with par_mode toggled after the start bit.
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 3, 1'b1);
    repeat (2) @(negedge clk);
    bus.par_mode = 1'b0;

    // Reset after 4 data bits: nothing delivered, outputs cleared.
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
    chk("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b0;
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b1;
    rst = 1'b0;
    chk("abort_data_out", {24'd0, bus.data_out},   32'd0);
    chk("abort_busy",     {31'd0, bus.busy},       32'd0);
    chk("abort_perr",     {31'd0, bus.parity_err}, 32'd0);
    chk("abort_ferr",     {31'd0, bus.frame_err},  32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("err_cnt_one", {24'd0, bus.err_cnt}, 32'd1);
    for (int n = 1; n < 300; n++) send_frame(8'(n), ~(^8'(n)), 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("err_cnt_hold", {24'd0, bus.err_cnt}, 32'd255);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cnt_rst", {24'd0, bus.err_cnt}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("all_frames_delivered", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
